// File: rtl/instr_fetch.sv
// Instruction fetch front end.
// Issues one word-aligned request at a time to instruction memory and
// buffers up to two responses for decode. A redirect flushes the buffer,
// and any response still in flight is discarded.
module instr_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [DATA_WIDTH-1:0] id_instr,
   output logic [DATA_WIDTH-1:0] id_pc,
   output logic [6:0]            op,
   output logic [2:0]            funct3,
   output logic                  funct7
);

   typedef enum logic [1:0] {IDLE, REQ, RSP, DROP} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
   logic [DATA_WIDTH-1:0] instr_q [2];
   logic [DATA_WIDTH-1:0] instr_d [2];
   logic [DATA_WIDTH-1:0] pc_q    [2];
   logic [DATA_WIDTH-1:0] pc_d    [2];
   logic [1:0]            count_q, count_d;

   logic                  push, pop, widx;
   logic [DATA_WIDTH-1:0] redir_pc;

   // The low address bits of a redirect are discarded by alignment.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign redir_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
   // A pop coinciding with a redirect is swallowed by the flush.
   assign pop      = id_valid && id_ready && !redirect;

   // Fetch sequencing: at most one request outstanding; redirect handling.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      push       = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect)                     fetch_pc_d = redir_pc;
            else if (en && count_q < 2'd2)    state_d    = REQ;
         end
         REQ: begin
            if (redirect) begin
               fetch_pc_d = redir_pc;
               state_d    = imem_gnt ? DROP : IDLE;
            end else if (imem_gnt) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
               state_d    = RSP;
            end
         end
         RSP: begin
            if (redirect) begin
               fetch_pc_d = redir_pc;
               state_d    = imem_rvalid ? IDLE : DROP;
            end else if (imem_rvalid) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         DROP: begin
            if (redirect)    fetch_pc_d = redir_pc;
            if (imem_rvalid) state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Two-entry buffer with entry 0 as head; a push lands behind whatever
   // survives this cycle's pop, which keeps order on simultaneous push/pop.
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      count_d = count_q;
      widx    = pop ? (count_q == 2'd2) : (count_q == 2'd1);
      if (redirect) begin
         count_d = 2'd0;
      end else begin
         if (pop) begin
            instr_d[0] = instr_q[1];
            pc_d[0]    = pc_q[1];
         end
         if (push) begin
            instr_d[widx] = imem_rdata;
            pc_d[widx]    = req_pc_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // State and buffer registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         count_q    <= '0;
         instr_q    <= '{default: '0};
         pc_q       <= '{default: '0};
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         count_q    <= count_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
      end
   end

   assign imem_req  = (state_q == REQ);
   assign imem_addr = imem_req ? fetch_pc_q : '0;
   assign id_valid  = (count_q != 2'd0);
   assign id_instr  = id_valid ? instr_q[0] : '0;
   assign id_pc     = id_valid ? pc_q[0]    : '0;
   assign op        = id_instr[6:0];
   assign funct3    = id_instr[14:12];
   assign funct7    = id_instr[30];

endmodule
